// File: rtl/comb_bist_pkg.sv
// Shared definitions for the combinational-gate BIST engine: golden-function
// opcodes and the sequencer state encoding.
package comb_bist_pkg;

  // Golden reduction selected through the OP parameter.
  localparam int OP_OR   = 0;
  localparam int OP_AND  = 1;
  localparam int OP_XOR  = 2;
  localparam int OP_NOR  = 3;
  localparam int OP_NAND = 4;
  localparam int OP_XNOR = 5;

  // Sequencer states. WAIT holds a vector for the settle time, CHECK samples
  // the gate response for one cycle, DONE holds the results until restarted.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  // True when an opcode names one of the supported reductions.
  function automatic bit op_is_legal(input int op);
    return (op >= OP_OR) && (op <= OP_XNOR);
  endfunction

endpackage

// File: rtl/comb_bist_if.sv
// Connection bundle between the BIST engine (slave) and whatever controls it
// and hosts the gate under test (master).
//
// Handshake: start is a single-cycle request with no ready/ack. It is accepted
// on the rising edge where the engine is in IDLE or DONE; while busy is high
// it is ignored and never queued. done stays high until the next accepted
// start or reset, and pass/fail_vec/err_cnt are only meaningful while done=1.
interface comb_bist_if #(
  parameter int N_IN = 2
) ();
  import comb_bist_pkg::*;

  logic            start;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN-1:0] fail_vec;
  logic [N_IN:0]   err_cnt;
  bist_state_e     st_dbg;

  // Controller / gate-host side.
  modport master (
    output start,
    output dut_out,
    input  dut_in,
    input  busy,
    input  done,
    input  pass,
    input  fail_vec,
    input  err_cnt,
    input  st_dbg
  );

  // BIST engine side.
  modport slave (
    input  start,
    input  dut_out,
    output dut_in,
    output busy,
    output done,
    output pass,
    output fail_vec,
    output err_cnt,
    output st_dbg
  );

endinterface

// File: rtl/comb_bist_checker_golden.sv
// Golden model of a single-output gate: a reduction of all inputs selected by
// OP. Purely combinational so other BIST flavours can reuse it directly.
module comb_golden_ref
  import comb_bist_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int OP   = OP_OR
) (
  input  logic [N_IN-1:0] vec,
  output logic            exp
);

  if (!op_is_legal(OP)) begin : g_bad_op
    $error("comb_golden_ref: OP must be in 0..5");
  end

  // Expected gate output for the current vector.
  always_comb begin
    exp = 1'b0;
    case (OP)
      OP_OR:   exp = |vec;
      OP_AND:  exp = &vec;
      OP_XOR:  exp = ^vec;
      OP_NOR:  exp = ~(|vec);
      OP_NAND: exp = ~(&vec);
      OP_XNOR: exp = ~(^vec);
      default: exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/comb_bist_checker.sv
// Exhaustive BIST sequencer for a small combinational gate. Walks every input
// vector onto the gate, holds each one for SETTLE cycles, then compares the
// response with the golden reduction and accumulates pass/fail results.
module comb_bist_checker
  import comb_bist_pkg::*;
#(
  parameter int N_IN         = 2,
  parameter int OP           = OP_OR,
  parameter int SETTLE       = 1,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  comb_bist_if.slave  bus
);

  // Settle counter only has to hold SETTLE itself.
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

  if (SETTLE < 1) begin : g_bad_settle
    $error("comb_bist_checker: SETTLE must be at least 1");
  end
  if ((N_IN < 1) || (N_IN > 8)) begin : g_bad_n_in
    $error("comb_bist_checker: N_IN must be in 1..8");
  end

  bist_state_e     state_q,    state_d;
  logic [N_IN-1:0] vec_q,      vec_d;
  logic [CW-1:0]   cnt_q,      cnt_d;
  logic [N_IN-1:0] dut_in_q,   dut_in_d;
  logic            pass_q,     pass_d;
  logic [N_IN-1:0] fail_vec_q, fail_vec_d;
  logic [N_IN:0]   err_cnt_q,  err_cnt_d;

  logic exp_bit;
  logic mismatch;
  logic stop_now;

  // Golden value is derived from the internal vector, never from dut_in.
  comb_golden_ref #(
    .N_IN (N_IN),
    .OP   (OP)
  ) u_golden (
    .vec (vec_q),
    .exp (exp_bit)
  );

  // Case-inequality so an unknown response counts as a failure in simulation;
  // synthesis reduces it to an ordinary inequality.
  always_comb begin
    mismatch = (bus.dut_out !== exp_bit);
  end

  // Next-state and result-update logic for the sweep sequencer.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    dut_in_d   = dut_in_q;
    pass_d     = pass_q;
    fail_vec_d = fail_vec_q;
    err_cnt_d  = err_cnt_q;
    stop_now   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d    = ST_WAIT;
          vec_d      = '0;
          dut_in_d   = '0;
          cnt_d      = CNT_LOAD;
          pass_d     = 1'b0;
          fail_vec_d = '0;
          err_cnt_d  = '0;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (mismatch) begin
          err_cnt_d = err_cnt_q + ERR_ONE;
          // Only the first failing vector of a sweep is recorded.
          if (err_cnt_q == '0) begin
            fail_vec_d = vec_q;
          end
          stop_now = (STOP_ON_FAIL != 0);
        end

        if (stop_now || (vec_q == VEC_LAST)) begin
          state_d = ST_DONE;
          // Verdict is frozen on entry to DONE, including this cycle's result.
          pass_d  = (err_cnt_d == '0);
        end else begin
          state_d  = ST_WAIT;
          vec_d    = vec_q + VEC_ONE;
          dut_in_d = vec_q + VEC_ONE;
          cnt_d    = CNT_LOAD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any partial sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      cnt_q      <= '0;
      dut_in_q   <= '0;
      pass_q     <= 1'b0;
      fail_vec_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      dut_in_q   <= dut_in_d;
      pass_q     <= pass_d;
      fail_vec_q <= fail_vec_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Status decoded straight from the state register.
  always_comb begin
    bus.dut_in   = dut_in_q;
    bus.busy     = (state_q == ST_WAIT) || (state_q == ST_CHECK);
    bus.done     = (state_q == ST_DONE);
    bus.pass     = pass_q;
    bus.fail_vec = fail_vec_q;
    bus.err_cnt  = err_cnt_q;
    bus.st_dbg   = state_q;
  end

endmodule
